// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount using 25/10/5 cent coins, largest
// coin first, one coin per hopper handshake, tracking per-coin inventory.
module change_dispenser #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned INIT_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [5:0]       req_amount,
  output logic             req_ready,
  output logic             ret_5,
  output logic             ret_10,
  output logic             ret_25,
  input  logic             hopper_ack,
  input  logic             refill,
  output logic             done,
  output logic             short,
  output logic [5:0]       remaining,
  output logic [CNT_W-1:0] inv_5,
  output logic [CNT_W-1:0] inv_10,
  output logic [CNT_W-1:0] inv_25
);

  localparam logic [CNT_W-1:0] InitCnt = CNT_W'(INIT_CNT);

  typedef enum logic [1:0] {StIdle, StSelect, StEject, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [2:0]       r_coin;        // one-hot {25, 10, 5}
  logic [2:0]       w_coin_sel;
  logic [5:0]       w_coin_val;
  logic [5:0]       w_amount_floor;
  logic [5:0]       r_remaining;
  logic [CNT_W-1:0] r_inv_5;
  logic [CNT_W-1:0] r_inv_10;
  logic [CNT_W-1:0] r_inv_25;

  // Largest coin that fits the unpaid amount and is still in stock.
  always_comb begin
    w_coin_sel = 3'b000;
    if (r_remaining >= 6'd25 && r_inv_25 != '0) begin
      w_coin_sel = 3'b100;
    end else if (r_remaining >= 6'd10 && r_inv_10 != '0) begin
      w_coin_sel = 3'b010;
    end else if (r_remaining >= 6'd5 && r_inv_5 != '0) begin
      w_coin_sel = 3'b001;
    end
  end

  // Value of the coin currently being ejected; request amount floored to a nickel.
  always_comb begin
    w_coin_val = 6'd0;
    unique case (r_coin)
      3'b100:  w_coin_val = 6'd25;
      3'b010:  w_coin_val = 6'd10;
      3'b001:  w_coin_val = 6'd5;
      default: w_coin_val = 6'd0;
    endcase
    w_amount_floor = req_amount - (req_amount % 6'd5);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (req_valid) w_state_nxt = StSelect;
      // No eligible coin covers both a zero balance and an exhausted inventory.
      StSelect: w_state_nxt = (w_coin_sel == 3'b000) ? StDone : StEject;
      StEject:  if (hopper_ack) w_state_nxt = StSelect;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // State, coin choice, balance and inventory registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_coin      <= 3'b000;
      r_remaining <= 6'd0;
      r_inv_5     <= InitCnt;
      r_inv_10    <= InitCnt;
      r_inv_25    <= InitCnt;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle) begin
        // Refill lands on the same edge as an accepted request, so the new
        // transaction already sees the full inventory.
        if (refill) begin
          r_inv_5  <= InitCnt;
          r_inv_10 <= InitCnt;
          r_inv_25 <= InitCnt;
        end
        if (req_valid) r_remaining <= w_amount_floor;
      end
      if (r_state == StSelect) r_coin <= w_coin_sel;
      // Selection guarantees the chosen counter is non-zero, so no wrap here.
      if (r_state == StEject && hopper_ack) begin
        r_remaining <= r_remaining - w_coin_val;
        if (r_coin[2]) r_inv_25 <= r_inv_25 - CNT_W'(1);
        if (r_coin[1]) r_inv_10 <= r_inv_10 - CNT_W'(1);
        if (r_coin[0]) r_inv_5  <= r_inv_5  - CNT_W'(1);
      end
    end
  end

  // Outputs decoded from state.
  always_comb begin
    req_ready = (r_state == StIdle) && !rst;
    ret_25    = (r_state == StEject) && r_coin[2];
    ret_10    = (r_state == StEject) && r_coin[1];
    ret_5     = (r_state == StEject) && r_coin[0];
    done      = (r_state == StDone);
    short     = (r_state == StDone) && (r_remaining != 6'd0);
    remaining = r_remaining;
    inv_5     = r_inv_5;
    inv_10    = r_inv_10;
    inv_25    = r_inv_25;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a default instance (INIT_CNT=8) and a small one
// (INIT_CNT=1), driven through shared stimulus gated by 'sel'.
module tb_change_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req_valid, hopper_ack, refill, sel;
  logic [5:0] req_amount;

  logic       rdy0, r5_0, r10_0, r25_0, done0, short0;
  logic       rdy1, r5_1, r10_1, r25_1, done1, short1;
  logic [5:0] rem0, rem1;
  logic [3:0] i5_0, i10_0, i25_0, i5_1, i10_1, i25_1;

  change_dispenser #(.CNT_W(4), .INIT_CNT(8)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_amount(req_amount),
    .req_ready(rdy0), .ret_5(r5_0), .ret_10(r10_0), .ret_25(r25_0),
    .hopper_ack(hopper_ack & ~sel), .refill(refill & ~sel), .done(done0), .short(short0),
    .remaining(rem0), .inv_5(i5_0), .inv_10(i10_0), .inv_25(i25_0)
  );

  change_dispenser #(.CNT_W(4), .INIT_CNT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_amount(req_amount),
    .req_ready(rdy1), .ret_5(r5_1), .ret_10(r10_1), .ret_25(r25_1),
    .hopper_ack(hopper_ack & sel), .refill(refill & sel), .done(done1), .short(short1),
    .remaining(rem1), .inv_5(i5_1), .inv_10(i10_1), .inv_25(i25_1)
  );

  // Observed view of whichever instance is selected.
  logic       o_rdy, o_done, o_short;
  logic [2:0] o_ret;
  logic [5:0] o_rem;
  logic [3:0] o_i25, o_i10, o_i5;
  assign o_rdy   = sel ? rdy1 : rdy0;
  assign o_done  = sel ? done1 : done0;
  assign o_short = sel ? short1 : short0;
  assign o_ret   = sel ? {r25_1, r10_1, r5_1} : {r25_0, r10_0, r5_0};
  assign o_rem   = sel ? rem1 : rem0;
  assign o_i25   = sel ? i25_1 : i25_0;
  assign o_i10   = sel ? i10_1 : i10_0;
  assign o_i5    = sel ? i5_1 : i5_0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: inventory per instance, greedy payout computed arithmetically.
  int minv[2][3];
  int init_v[2] = '{8, 1};
  int cval[3] = '{25, 10, 5};
  int exp_q[$];
  int exp_rem;

  function automatic void model_fill(input int d);
    for (int k = 0; k < 3; k++) minv[d][k] = init_v[d];
  endfunction

  function automatic void model_pay(input int d, input int amt);
    int rem;
    bit found;
    rem = amt - (amt % 5);
    exp_q.delete();
    while (rem > 0) begin
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (!found && cval[k] <= rem && minv[d][k] > 0) begin
          found = 1'b1;
          exp_q.push_back(cval[k]);
          minv[d][k]--;
          rem -= cval[k];
        end
      end
      if (!found) break;
    end
    exp_rem = rem;
  endfunction

  task automatic chk_inv(input string tag);
    int d;
    d = sel ? 1 : 0;
    chk({tag, "_inv25"}, o_i25, minv[d][0]);
    chk({tag, "_inv10"}, o_i10, minv[d][1]);
    chk({tag, "_inv5"},  o_i5,  minv[d][2]);
  endtask

  int obs_q[$];
  int obs_first, obs_short, obs_rem;

  // One full transaction from IDLE back to IDLE; 'hold' is how many cycles each
  // ret stays high before the ack, 'noise' adds ignored req/refill/ack activity.
  task automatic run_txn(input int amt, input bit rf, input int hold, input bit noise);
    int  cyc, held, d;
    bit  fin;
    d = sel ? 1 : 0;
    obs_q.delete();
    obs_first = -1;
    chk("idle_ready", o_rdy, 1);
    req_valid = 1'b1; req_amount = amt[5:0]; refill = rf;
    step();
    req_valid = 1'b0; refill = 1'b0;
    if (rf) model_fill(d);
    model_pay(d, amt);
    cyc = 1; held = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      chk("ret_onehot", int'($countones(o_ret) <= 1), 1);
      if (obs_first < 0 && (o_ret != 3'b000 || o_done)) obs_first = cyc;
      if (o_done) begin
        fin = 1'b1;
        obs_short = o_short;
        obs_rem = o_rem;
        hopper_ack = 1'b0; req_valid = 1'b0; refill = 1'b0;
      end else begin
        chk("busy_ready", o_rdy, 0);
        if (o_ret != 3'b000) begin
          if (held == 0) obs_q.push_back(o_ret[2] ? 25 : (o_ret[1] ? 10 : 5));
          held++;
          hopper_ack = (held >= hold);
        end else begin
          if (held != 0) chk("hold_len", held, hold);
          held = 0;
          hopper_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (noise) begin
          req_valid  = 1'($urandom_range(0, 1));
          req_amount = 6'($urandom_range(0, 63));
          refill     = 1'($urandom_range(0, 1));
        end
        step();
        cyc++;
      end
    end
    if (!fin) begin
      chk("txn_timeout", cyc, -1);
      hopper_ack = 1'b0; req_valid = 1'b0; refill = 1'b0;
    end
    chk("latency", obs_first, 2);
    chk("n_coins", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("coin%0d", i), obs_q[i], exp_q[i]);
    chk("short", obs_short, int'(exp_rem != 0));
    chk("remaining", obs_rem, exp_rem);
    step();
    chk("post_ready", o_rdy, 1);
    chk("post_done", o_done, 0);
    chk("post_rem_hold", o_rem, exp_rem);
    chk_inv("post");
  endtask

  typedef struct {
    int amt; bit rf; int hold; bit noise;
    int n25; int n10; int n5;
    bit shrt; int rem; int i25; int i10; int i5;
  } vec_t;

  localparam int NVec = 14;
  vec_t tbl[NVec];
  int   tq[$];
  int   cyc;

  initial begin
    // Stateful table for the INIT_CNT=8 instance, starting from a fresh reset.
    tbl[0]  = '{40, 1'b0, 2, 1'b0, 1, 1, 1, 1'b0, 0,  7, 7, 7};
    tbl[1]  = '{0,  1'b0, 1, 1'b0, 0, 0, 0, 1'b0, 0,  7, 7, 7};
    tbl[2]  = '{37, 1'b0, 1, 1'b0, 1, 1, 0, 1'b0, 0,  6, 6, 7};
    tbl[3]  = '{63, 1'b0, 4, 1'b1, 2, 1, 0, 1'b0, 0,  4, 5, 7};
    tbl[4]  = '{4,  1'b0, 1, 1'b0, 0, 0, 0, 1'b0, 0,  4, 5, 7};
    tbl[5]  = '{60, 1'b1, 1, 1'b0, 2, 1, 0, 1'b0, 0,  6, 7, 8};
    tbl[6]  = '{60, 1'b0, 1, 1'b0, 2, 1, 0, 1'b0, 0,  4, 6, 8};
    tbl[7]  = '{50, 1'b0, 1, 1'b0, 2, 0, 0, 1'b0, 0,  2, 6, 8};
    tbl[8]  = '{50, 1'b0, 1, 1'b0, 2, 0, 0, 1'b0, 0,  0, 6, 8};
    tbl[9]  = '{30, 1'b0, 1, 1'b0, 0, 3, 0, 1'b0, 0,  0, 3, 8};
    tbl[10] = '{45, 1'b0, 2, 1'b1, 0, 3, 3, 1'b0, 0,  0, 0, 5};
    tbl[11] = '{60, 1'b0, 1, 1'b0, 0, 0, 5, 1'b1, 35, 0, 0, 0};
    tbl[12] = '{15, 1'b0, 1, 1'b0, 0, 0, 0, 1'b1, 15, 0, 0, 0};
    tbl[13] = '{5,  1'b1, 1, 1'b0, 0, 0, 1, 1'b0, 0,  8, 8, 7};

    rst = 1'b1; req_valid = 1'b0; hopper_ack = 1'b0; refill = 1'b0; sel = 1'b0;
    req_amount = 6'd0;
    model_fill(0); model_fill(1);
    step(); step();
    chk("rst_ready", o_rdy, 0);
    chk("rst_ret", o_ret, 0);
    chk("rst_done", o_done, 0);
    chk("rst_short", o_short, 0);
    chk("rst_rem", o_rem, 0);
    chk_inv("rst0");
    sel = 1'b1; #1;
    chk_inv("rst1");
    sel = 1'b0;
    rst = 1'b0; #1;
    chk("ready_after_rst", o_rdy, 1);

    for (int v = 0; v < NVec; v++) begin
      run_txn(tbl[v].amt, tbl[v].rf, tbl[v].hold, tbl[v].noise);
      tq.delete();
      for (int k = 0; k < tbl[v].n25; k++) tq.push_back(25);
      for (int k = 0; k < tbl[v].n10; k++) tq.push_back(10);
      for (int k = 0; k < tbl[v].n5; k++)  tq.push_back(5);
      chk($sformatf("tbl%0d_ncoin", v), obs_q.size(), tq.size());
      for (int i = 0; i < tq.size() && i < obs_q.size(); i++)
        chk($sformatf("tbl%0d_coin%0d", v, i), obs_q[i], tq[i]);
      chk($sformatf("tbl%0d_short", v), obs_short, int'(tbl[v].shrt));
      chk($sformatf("tbl%0d_rem", v), obs_rem, tbl[v].rem);
      chk($sformatf("tbl%0d_inv25", v), o_i25, tbl[v].i25);
      chk($sformatf("tbl%0d_inv10", v), o_i10, tbl[v].i10);
      chk($sformatf("tbl%0d_inv5", v), o_i5, tbl[v].i5);
    end

    // Single-coin inventory: 50 cents cannot be fully paid, then refill in IDLE.
    sel = 1'b1; #1;
    run_txn(50, 1'b0, 1, 1'b0);
    chk("s1_ncoin", obs_q.size(), 3);
    chk("s1_short", obs_short, 1);
    chk("s1_rem", obs_rem, 10);
    chk("s1_inv25", o_i25, 0);
    chk("s1_inv10", o_i10, 0);
    chk("s1_inv5", o_i5, 0);
    refill = 1'b1; step(); refill = 1'b0;
    model_fill(1);
    chk("s1_refill_inv25", o_i25, 1);
    chk("s1_refill_inv10", o_i10, 1);
    chk("s1_refill_inv5", o_i5, 1);
    sel = 1'b0; #1;

    // Reset while a coin is being ejected aborts the transaction silently.
    req_valid = 1'b1; req_amount = 6'd40; step(); req_valid = 1'b0;
    cyc = 0;
    while (o_ret == 3'b000 && cyc < 10) begin step(); cyc++; end
    chk("rst_eject_ret25", o_ret, 3'b100);
    rst = 1'b1; step();
    model_fill(0); model_fill(1);
    chk("rst_eject_ret", o_ret, 0);
    chk("rst_eject_rem", o_rem, 0);
    chk("rst_eject_done", o_done, 0);
    chk("rst_eject_ready", o_rdy, 0);
    chk_inv("rst_eject");
    step();
    chk("rst_eject_done2", o_done, 0);
    rst = 1'b0; #1;
    chk("rst_eject_ready_after", o_rdy, 1);
    chk("rst_eject_done3", o_done, 0);
    sel = 1'b1; #1;
    chk_inv("rst_eject1");
    sel = 1'b0; #1;

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        refill = 1'b1; step(); refill = 1'b0;
        model_fill(0);
        chk_inv("rand_refill");
      end
      run_txn($urandom_range(0, 63), $urandom_range(0, 4) == 0, $urandom_range(1, 3),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
